lsu_pipe: RTL

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_pipe_if.sv | 22 ++
 rtl/lsu_bank_ram.sv | 67 ++++++
 rtl/lsu_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default address map for the LSU pipeline.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    REG_DMEM   = 2'd0,
    REG_IO_OUT = 2'd1,
    REG_IO_IN  = 2'd2,
    REG_NONE   = 2'd3
  } region_e;

  localparam logic [31:0] IO_OUT_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] IO_IN_BASE_DEF  = 32'h1001_0000;

  // Byte-lane mask for an access of size funct3[1:0], before shifting by the offset.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// Request/response bus between a requester (master) and lsu_pipe (slave).
interface lsu_pipe_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wren;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/lsu_bank_ram.sv
// Even/odd word banks so that words W and W+1 are always read and written in the same cycle.
// Lane A is word W, lane B is word W+1; contents are never cleared.
module lsu_bank_ram #(
  parameter int DMEM_AW = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [DMEM_AW-3:0] word_i,
  input  logic [3:0]         be_a_i,
  input  logic [3:0]         be_b_i,
  input  logic [31:0]        wdata_a_i,
  input  logic [31:0]        wdata_b_i,
  output logic [31:0]        rdata_a_o,
  output logic [31:0]        rdata_b_o
);

  localparam int BW = DMEM_AW - 3;

  logic [31:0]   even_mem [2**BW];
  logic [31:0]   odd_mem  [2**BW];
  logic [BW-1:0] half_s, even_idx_s, odd_idx_s;
  logic [3:0]    even_be_s, odd_be_s;
  logic [31:0]   even_wd_s, odd_wd_s;
  logic [31:0]   even_rd_q, odd_rd_q;
  logic          odd_q;

  // Odd W puts lane A in the odd bank and lane B in the next even row; the index wraps harmlessly past the top.
  always_comb begin
    half_s = word_i[DMEM_AW-3:1];
    if (word_i[0]) begin
      odd_idx_s  = half_s;
      even_idx_s = half_s + {{(BW-1){1'b0}}, 1'b1};
      odd_be_s   = be_a_i;
      even_be_s  = be_b_i;
      odd_wd_s   = wdata_a_i;
      even_wd_s  = wdata_b_i;
    end else begin
      odd_idx_s  = half_s;
      even_idx_s = half_s;
      odd_be_s   = be_b_i;
      even_be_s  = be_a_i;
      odd_wd_s   = wdata_b_i;
      even_wd_s  = wdata_a_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (even_be_s[b]) even_mem[even_idx_s][8*b +: 8] <= even_wd_s[8*b +: 8];
      if (odd_be_s[b])  odd_mem[odd_idx_s][8*b +: 8]   <= odd_wd_s[8*b +: 8];
    end
    even_rd_q <= even_mem[even_idx_s];
    odd_rd_q  <= odd_mem[odd_idx_s];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      odd_q <= 1'b0;
    end else begin
      odd_q <= word_i[0];
    end
  end

  assign rdata_a_o = odd_q ? odd_rd_q  : even_rd_q;
  assign rdata_b_o = odd_q ? even_rd_q : odd_rd_q;

endmodule

// File: rtl/lsu_pipe.sv
// Load/store pipe: accepts one request per cycle and responds the next cycle (DMEM + memory-mapped IO).
// Build option LSU_MISALIGN_EN: unaligned DMEM halfword/word accesses complete across words W and W+1.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int          DMEM_AW     = 16,
  parameter int          N_IO_OUT    = 5,
  parameter int          N_IO_IN     = 1,
  parameter logic [31:0] IO_OUT_BASE = IO_OUT_BASE_DEF,
  parameter logic [31:0] IO_IN_BASE  = IO_IN_BASE_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  lsu_pipe_if.slave                 bus,
  output logic [N_IO_OUT-1:0][31:0] o_io_out,
  input  logic [N_IO_IN-1:0][31:0]  i_io_in
);

  logic        accept_s, err_s, misal_s, f3_ok_s, oob_s, dmem_we_s, io_we_s;
  logic [1:0]  off_s;
  logic [3:0]  mask_s, be_w_s, be_a_s, be_b_s;
  logic [31:0] wd_w_s, wd_b_s, io_rd_s, io_out_off_s, io_in_off_s;
  logic [31:0] ram_rd_a_s, ram_rd_b_s, shifted_s, ext_s, rdata_s;
  logic [32:0] end_s;
  logic [63:0] rd_src_s;
  region_e     region_s;

  logic [N_IO_OUT-1:0][31:0] io_out_d, io_out_q;
  logic [N_IO_IN-1:0][31:0]  sync1_q, sync2_q;
  logic        rsp_valid_d, rsp_valid_q, rsp_err_d, rsp_err_q, load_d, load_q;
  logic [2:0]  f3_d, f3_q;
  logic [1:0]  off_d, off_q;
  region_e     region_d, region_q;
  logic [31:0] io_word_d, io_word_q;

  // Decode: region, alignment, DMEM upper bound and fault classification.
  always_comb begin
    off_s        = bus.i_req_addr[1:0];
    mask_s       = size_mask(bus.i_req_funct3[1:0]);
    io_out_off_s = bus.i_req_addr - IO_OUT_BASE;
    io_in_off_s  = bus.i_req_addr - IO_IN_BASE;
    end_s        = {1'b0, bus.i_req_addr} + (33'd1 << bus.i_req_funct3[1:0]);
    oob_s        = end_s > (33'd1 << DMEM_AW);
    misal_s      = ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) ||
                   ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));
    case (bus.i_req_funct3)
      F3_B, F3_H, F3_W: f3_ok_s = 1'b1;
      F3_BU, F3_HU:     f3_ok_s = !bus.i_req_wren;
      default:          f3_ok_s = 1'b0;
    endcase
    if (bus.i_req_addr[31:DMEM_AW] == {(32-DMEM_AW){1'b0}}) begin
      region_s = REG_DMEM;
    end else if (((io_out_off_s[11:0] & 12'hFFC) == 12'h000) &&
                 ({12'h000, io_out_off_s[31:12]} < 32'(N_IO_OUT))) begin
      region_s = REG_IO_OUT;
    end else if (((io_in_off_s[11:0] & 12'hFFC) == 12'h000) &&
                 ({12'h000, io_in_off_s[31:12]} < 32'(N_IO_IN))) begin
      region_s = REG_IO_IN;
    end else begin
      region_s = REG_NONE;
    end
    err_s = 1'b1;
    if (f3_ok_s) begin
      case (region_s)
`ifdef LSU_MISALIGN_EN
        REG_DMEM:   err_s = oob_s;
`else
        REG_DMEM:   err_s = oob_s || misal_s;
`endif
        REG_IO_OUT: err_s = misal_s;
        REG_IO_IN:  err_s = misal_s || bus.i_req_wren;
        default:    err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b1;
    end
  end

  // Byte lanes: word W gets mask<<off, word W+1 gets the bytes that spill past lane 3.
  always_comb begin
    accept_s  = bus.i_req_valid && !i_reset;
    be_w_s    = mask_s << off_s;
    wd_w_s    = bus.i_req_wdata << {off_s, 3'b000};
    dmem_we_s = accept_s && bus.i_req_wren && !err_s && (region_s == REG_DMEM);
    io_we_s   = accept_s && bus.i_req_wren && !err_s && (region_s == REG_IO_OUT);
    be_a_s    = dmem_we_s ? be_w_s : 4'b0000;
`ifdef LSU_MISALIGN_EN
    be_b_s    = dmem_we_s ? (mask_s >> (3'd4 - {1'b0, off_s})) : 4'b0000;
    wd_b_s    = bus.i_req_wdata >> (6'd32 - {1'b0, off_s, 3'b000});
`else
    be_b_s    = 4'b0000;
    wd_b_s    = 32'h0000_0000;
`endif
  end

  always_comb begin
    io_out_d = io_out_q;
    for (int k = 0; k < N_IO_OUT; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (io_we_s && be_w_s[b] && (io_out_off_s[31:12] == 20'(k))) begin
          io_out_d[k][8*b +: 8] = wd_w_s[8*b +: 8];
        end else begin
          io_out_d[k][8*b +: 8] = io_out_q[k][8*b +: 8];
        end
      end
    end
    io_rd_s = 32'h0000_0000;
    if (region_s == REG_IO_OUT) begin
      for (int k = 0; k < N_IO_OUT; k++) begin
        io_rd_s = (io_out_off_s[31:12] == 20'(k)) ? io_out_q[k] : io_rd_s;
      end
    end else if (region_s == REG_IO_IN) begin
      for (int k = 0; k < N_IO_IN; k++) begin
        io_rd_s = (io_in_off_s[31:12] == 20'(k)) ? sync2_q[k] : io_rd_s;
      end
    end else begin
      io_rd_s = 32'h0000_0000;
    end
  end

  always_comb begin
    rsp_valid_d = accept_s;
    rsp_err_d   = accept_s && err_s;
    load_d      = accept_s && !bus.i_req_wren && !err_s;
    f3_d        = accept_s ? bus.i_req_funct3 : f3_q;
    off_d       = accept_s ? off_s : off_q;
    region_d    = accept_s ? region_s : region_q;
    io_word_d   = accept_s ? io_rd_s : io_word_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      io_out_q    <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      load_q      <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      region_q    <= REG_DMEM;
      io_word_q   <= 32'h0000_0000;
    end else begin
      io_out_q    <= io_out_d;
      sync1_q     <= i_io_in;
      sync2_q     <= sync1_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      load_q      <= load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      region_q    <= region_d;
      io_word_q   <= io_word_d;
    end
  end

  lsu_bank_ram #(.DMEM_AW(DMEM_AW)) u_ram (
    .clk_i     (i_clk),
    .reset_i   (i_reset),
    .word_i    (bus.i_req_addr[DMEM_AW-1:2]),
    .be_a_i    (be_a_s),
    .be_b_i    (be_b_s),
    .wdata_a_i (wd_w_s),
    .wdata_b_i (wd_b_s),
    .rdata_a_o (ram_rd_a_s),
    .rdata_b_o (ram_rd_b_s)
  );

  // Response: funnel-shift the bank pair (or the captured IO word) by the registered offset, then extend.
  always_comb begin
    rd_src_s  = (region_q == REG_DMEM) ? {ram_rd_b_s, ram_rd_a_s} : {32'h0000_0000, io_word_q};
    shifted_s = 32'(rd_src_s >> {off_q, 3'b000});
    case (f3_q)
      F3_B:    ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    ext_s = shifted_s;
      F3_BU:   ext_s = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   ext_s = {16'h0000, shifted_s[15:0]};
      default: ext_s = 32'h0000_0000;
    endcase
    rdata_s = load_q ? ext_s : 32'h0000_0000;
  end

  assign bus.o_req_ready = !i_reset;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rdata_s;
  assign o_io_out        = io_out_q;

endmodule
